// File: rtl/rpa_pkg.sv
// rpa_pkg: shared helpers for the pipelined reversible ripple adder.
//   rpa_params_ok : legality of a WIDTH/STAGES pair (STAGES divides WIDTH)
//   rpa_chunk     : bits handled by each pipeline stage
//   peres         : Peres gate (P = a, Q = a^b, R = a&b ^ c), packed {P,Q,R}
package rpa_pkg;

  function automatic bit rpa_params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Falls back to the full width for a nonsense stage count so that the
  // elaboration error below is the message the user sees, not a width error.
  function automatic int rpa_chunk(input int width, input int stages);
    return (stages >= 1) ? (width / stages) : width;
  endfunction

  function automatic logic [2:0] peres(input logic a, input logic b, input logic c);
    return {a, a ^ b, (a & b) ^ c};
  endfunction

endpackage

// File: rtl/rev_fa_peres.sv
// rev_fa_peres: full adder built from two cascaded Peres gates.
//   a, b, ci : addend bits and carry in
//   s, co    : sum and carry out
//   g0, g1   : garbage outputs of the reversible construction (a, a^b)
module rev_fa_peres
  import rpa_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co,
  output logic g0,
  output logic g1
);

  logic [2:0] p1;
  logic [2:0] p2;

  // First gate with a constant-0 ancilla: {a, a^b, a&b}.
  assign p1 = peres(a, b, 1'b0);
  // Second gate folds in ci: Q = a^b^ci, R = (a^b)&ci ^ a&b = majority.
  assign p2 = peres(p1[1], ci, p1[0]);

  assign s  = p2[1];
  assign co = p2[0];
  assign g0 = p1[2];
  assign g1 = p2[2];

endmodule

// File: rtl/rpa_pipe.sv
// rpa_pipe: pipelined WIDTH-bit adder/subtractor, STAGES chunks of
// WIDTH/STAGES bits, each chunk rippled through rev_fa_peres cells.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : operand handshake (a, b, sub, cin)
//   out_valid/out_ready       : result handshake (sum, cout, ovf)
//   sub=1 computes a - b (cin ignored); cout=1 then means no borrow.
// Stall-all pipeline: every register advances only when the output slot is
// empty or being drained. Latency is STAGES+1 register levels (STAGES stage
// registers plus the output register).
module rpa_pipe
  import rpa_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = rpa_chunk(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!rpa_params_ok(WIDTH, STAGES)) begin : g_param_check
    $error("rpa_pipe: STAGES must divide WIDTH and satisfy 1 <= STAGES <= WIDTH");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign adv      = !out_valid_q | out_ready;
  assign in_ready = adv;
  // Subtraction as A + ~B + 1; inversion happens once at the input so the
  // skew registers carry B' directly.
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub | cin;

  genvar gi, gj;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO  = gi * CHUNK;                 // first bit of this chunk
    localparam int REM = WIDTH - (gi + 1) * CHUNK;   // operand bits still pending

    logic [CHUNK-1:0]    op_a;
    logic [CHUNK-1:0]    op_b;
    logic [CHUNK-1:0]    s_chunk;
    logic [CHUNK:0]      cc;
    logic                valid_in;
    logic [LO+CHUNK-1:0] sum_d;
    logic [LO+CHUNK-1:0] sum_q;
    logic                v_q;
    logic                c_q;

    if (gi == 0) begin : g_src
      assign op_a     = a[CHUNK-1:0];
      assign op_b     = b_eff[CHUNK-1:0];
      assign cc[0]    = cin_eff;
      assign valid_in = in_valid;
      assign sum_d    = s_chunk;
    end else begin : g_src
      assign op_a     = g_stage[gi-1].g_rem.a_q[CHUNK-1:0];
      assign op_b     = g_stage[gi-1].g_rem.b_q[CHUNK-1:0];
      assign cc[0]    = g_stage[gi-1].c_q;
      assign valid_in = g_stage[gi-1].v_q;
      // Completed low chunks ride along so the whole sum leaves together.
      assign sum_d    = {s_chunk, g_stage[gi-1].sum_q};
    end

    for (gj = 0; gj < CHUNK; gj++) begin : g_cell
      rev_fa_peres u_fa (
        .a  (op_a[gj]),
        .b  (op_b[gj]),
        .ci (cc[gj]),
        .s  (s_chunk[gj]),
        .co (cc[gj+1]),
        .g0 (),
        .g1 ()
      );
    end

    // Operand skew: the chunks not yet added wait here, shifted down so the
    // next stage always finds its chunk at bit 0.
    if (REM > 0) begin : g_rem
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (gi == 0) begin : g_ld
        assign a_d = a[WIDTH-1:CHUNK];
        assign b_d = b_eff[WIDTH-1:CHUNK];
      end else begin : g_ld
        assign a_d = g_stage[gi-1].g_rem.a_q[REM+CHUNK-1:CHUNK];
        assign b_d = g_stage[gi-1].g_rem.b_q[REM+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= valid_in;
        c_q   <= cc[CHUNK];
        sum_q <= sum_d;
      end
    end

    // Signed overflow needs the carry into the MSB cell, only visible here.
    if (gi == LAST) begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= cc[CHUNK-1] ^ cc[CHUNK];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= g_stage[LAST].v_q;
      sum_q       <= g_stage[LAST].sum_q;
      cout_q      <= g_stage[LAST].c_q;
      ovf_q       <= g_stage[LAST].g_ovf.ovf_q;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/rpa_pipe.md
# rpa_pipe

Pipelined, parametrised ripple adder/subtractor built from reversible Peres-gate full-adder cells. A WIDTH-bit operation is split into STAGES equal chunks; each pipeline stage ripples one chunk and registers its carry into the next. Operands enter through a valid/ready handshake and results leave through one. Accepts one operation per cycle. It is the throughput-oriented arithmetic block for datapaths wider than a single-cycle ripple chain can close timing on.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline stages; 1 ≤ STAGES ≤ WIDTH. CHUNK = WIDTH/STAGES bits per stage.

- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B+cin; 1: A−B (A + ~B + 1; cin ignored).
- cin  input  1  carry-in for add mode.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB. In subtract mode, 1 means no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR cout.

## Operation
- Stage k (0..STAGES−1) adds bits [k·CHUNK +: CHUNK] of A and B' = sub ? ~B : B.
  - Carry-in for stage 0: sub ? 1 : cin. For stage k>0: the carry registered by stage k−1.
- Operand skew: chunk k of A/B' is delayed k cycles through per-stage registers so it meets its carry. Completed sum chunks are de-skewed so all WIDTH bits of one operation leave together.
- Each stage holds a valid bit. A beat moves forward only under the global advance signal.
- adv = !out_valid | out_ready. All stage registers, including the output register, load only when adv=1.
- in_ready = adv. A transfer occurs when in_valid & in_ready.
- Empty slots (valid=0) flow like data. Bubbles are not compressed; this is a stall-all pipeline.
- ovf: XOR of the MSB cell's carry-in and carry-out, captured in the final stage.
- Peres garbage outputs are left unconnected. They are not registered.
- Arithmetic is modulo 2^WIDTH. The result is bit-exact to {cout,sum} = A + B' + cin_eff.

## Timing
- Reset (rst=1 at a clock edge): all stage valid bits, out_valid, sum, cout, ovf are cleared to 0. in_ready reads 1 the cycle after reset (adv=1 because out_valid=0).
- Reset mid-operation: all in-flight beats are discarded with no partial output. A beat presented while rst=1 is not accepted.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and every register holds. sum/cout/ovf stay stable until the handshake completes.
- Simultaneous output handshake and input accept in the same cycle is legal. The pipeline shifts by one with no bubble.
- in_ready depends combinationally on out_ready. There is no other input-to-output combinational path.
- STAGES=1 degenerates to a one-register full-width ripple with the same handshake.

## Structure
- Shared package (rpa_pkg): a function checking that WIDTH % STAGES == 0, and a localparam CHUNK derivation helper. Elaboration fails on an illegal parameter pair.
- Sub-module rev_fa_peres: a two-Peres-gate full adder (a, b, ci → s, co, two garbage outputs), reusing the existing peres gate.
- Each stage is a generate loop of CHUNK rev_fa_peres cells plus its registers. No further hierarchy.

## Test plan (WIDTH=16, STAGES=4 unless noted)
- Add, no backpressure: A=0x1234, B=0x0FF0, cin=1, sub=0, out_ready=1 → 4 cycles later sum=0x2225, cout=0, ovf=0.
- Carry ripples across all stages: A=0xFFFF, B=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then A=0x7FFF, B=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract: A=0x0005, B=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0 (borrow), ovf=0.
- Streaming with stall: 8 back-to-back random beats; hold out_ready=0 for 3 cycles mid-stream → in_ready=0 during the stall, outputs stable, all 8 results in order and matching the reference model, none lost or duplicated.
- Reset mid-flight: accept 3 beats, assert rst for one cycle → out_valid never rises for those beats; the next beat accepted yields its result 4 cycles later.
- Parameter sweep: random streams at (8,1), (16,16), (32,4) against the reference model. (16,3) fails elaboration.
